push_button_conditioner: RTL and testbench



---
 rtl/push_button_conditioner.sv | 148 ++++++++++++++
 tb/tb_push_button_conditioner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/push_button_conditioner.sv
// rtl/push_button_conditioner.sv - per-button synchroniser, debouncer and press/release/repeat strobes
// Auto-repeat FSM per button is built only when AUTO_REPEAT_EN is defined; otherwise btn_repeat mirrors btn_press.
module push_button_conditioner #(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int REPEAT_DELAY    = 500000,
   parameter int REPEAT_PERIOD   = 150000,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] push_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat,
   output logic             any_press
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
      $error("push_button_conditioner: cycle parameters must be at least 2");
   end

`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DELAY = 2'd1,
      S_RPT   = 2'd2
   } rpt_state_e;
`endif

   logic [N_BTN-1:0] press_d;
   logic             any_press_q;

   for (genvar b = 0; b < N_BTN; b++) begin : g_btn
      logic             sync1_q, sync2_q;
      logic             level_q, level_d;
      logic             press_q, release_q;
      logic             rise_d, fall_d;
      logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

      always_ff @(posedge clk) begin
         if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            sync1_q   <= push_raw[b];
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= rise_d;
            release_q <= fall_d;
         end
      end

      // Count only while the synchronised pin disagrees with the accepted level.
      always_comb begin
         db_cnt_d = '0;
         level_d  = level_q;
         rise_d   = 1'b0;
         fall_d   = 1'b0;
         if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
               level_d = ~level_q;
               rise_d  = ~level_q;
               fall_d  = level_q;
            end else begin
               db_cnt_d = db_cnt_q + CNT_W'(1);
            end
         end
      end

      assign press_d[b]     = rise_d;
      assign btn_level[b]   = level_q;
      assign btn_press[b]   = press_q;
      assign btn_release[b] = release_q;

`ifdef AUTO_REPEAT_EN
      rpt_state_e       state_q, state_d;
      logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
      logic             repeat_q, repeat_d;

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q   <= S_IDLE;
            rpt_cnt_q <= '0;
            repeat_q  <= 1'b0;
         end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            repeat_q  <= repeat_d;
         end
      end

      always_comb begin
         state_d   = state_q;
         rpt_cnt_d = '0;
         case (state_q)
            S_IDLE: begin
               if (rise_d) state_d = S_DELAY;
            end
            S_DELAY: begin
               if (fall_d)                    state_d = S_IDLE;
               else if (rpt_cnt_q == RD_LAST) state_d = S_RPT;
               else                           rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
            end
            S_RPT: begin
               if (fall_d)                    state_d = S_IDLE;
               else if (rpt_cnt_q != RP_LAST) rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
         endcase
      end

      // A debounced fall suppresses a coincident terminal-count strobe.
      always_comb begin
         repeat_d = 1'b0;
         case (state_q)
            S_IDLE:  repeat_d = rise_d;
            S_DELAY: repeat_d = !fall_d && (rpt_cnt_q == RD_LAST);
            S_RPT:   repeat_d = !fall_d && (rpt_cnt_q == RP_LAST);
            default: repeat_d = 1'b0;
         endcase
      end

      assign btn_repeat[b] = repeat_q;
`else
      assign btn_repeat[b] = press_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) any_press_q <= 1'b0;
      else       any_press_q <= |press_d;
   end

   assign any_press = any_press_q;

endmodule

// File: tb/tb_push_button_conditioner.sv
// tb/tb_push_button_conditioner.sv - scoreboard bench for push_button_conditioner
// Expected repeat strobes depend on whether AUTO_REPEAT_EN is defined for the build.
module tb_push_button_conditioner;

`ifdef AUTO_REPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] cyc;
      logic [4:0]  level;
      logic [4:0]  press;
      logic [4:0]  rel;
      logic [4:0]  rpt;
      logic        any;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] push_raw = 5'b11111;
   logic [4:0] btn_level, btn_press, btn_release, btn_repeat;
   logic       any_press;

   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;
   ev_t exp_q[$];
   ev_t obs_q[$];

   push_button_conditioner #(
      .N_BTN(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .push_raw(push_raw),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
      .btn_repeat(btn_repeat), .any_press(any_press)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t ev(input int c, input logic [4:0] l, input logic [4:0] p,
                              input logic [4:0] r, input logic [4:0] t, input logic a);
      ev_t e;
      e.cyc = c; e.level = l; e.press = p; e.rel = r; e.rpt = t; e.any = a;
      return e;
   endfunction

   // Monitor: every cycle with any strobe becomes an observed event.
   always @(negedge clk) begin
      if ((btn_press | btn_release | btn_repeat) != 5'h0 || any_press)
         obs_q.push_back(ev(cyc, btn_level, btn_press, btn_release, btn_repeat, any_press));
   end

   task automatic test_reset();
      int r;
      reset = 1'b1;
      push_raw = 5'b11111;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if ({btn_level, btn_press, btn_release, btn_repeat, any_press} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0",
                     {btn_level, btn_press, btn_release, btn_repeat, any_press});
         end
      end
      reset = 1'b0;
      r = cyc;
      exp_q.push_back(ev(r + 6, 5'h1f, 5'h1f, 5'h0, 5'h1f, 1'b1));
      repeat (5) @(negedge clk);
      n_checks++;
      if (btn_level !== 5'h00) begin
         n_fail++; $display("FAIL reset_level_early got %b want 00000", btn_level);
      end
      @(negedge clk);
      n_checks++;
      if (btn_level !== 5'h1f) begin
         n_fail++; $display("FAIL reset_level_accept got %b want 11111", btn_level);
      end
      push_raw = 5'h0;
      exp_q.push_back(ev(r + 12, 5'h0, 5'h0, 5'h1f, 5'h0, 1'b0));
      repeat (12) @(negedge clk);
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL reset event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL reset event got cyc %0d %h want cyc %0d %h", o.cyc, o, e.cyc, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid_press();
      int k;
      k = cyc;
      push_raw = 5'b01000;
      exp_q.push_back(ev(k + 6, 5'h08, 5'h08, 5'h0, 5'h08, 1'b1));
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_repeat} !== 15'd0) begin
         n_fail++; $display("FAIL midreset_clear got %h want 0", {btn_level, btn_press, btn_repeat});
      end
      reset = 1'b0;
      exp_q.push_back(ev(k + 15, 5'h08, 5'h08, 5'h0, 5'h08, 1'b1));
      repeat (6) @(negedge clk);
      push_raw = 5'h0;
      exp_q.push_back(ev(k + 21, 5'h0, 5'h0, 5'h08, 5'h0, 1'b0));
      repeat (12) @(negedge clk);
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL midreset event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL midreset event got cyc %0d %h want cyc %0d %h", o.cyc, o, e.cyc, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_glitch();
      push_raw = 5'b00001;
      repeat (3) @(negedge clk);
      push_raw = 5'h0;
      repeat (10) begin
         @(negedge clk);
         n_checks++;
         if (btn_level[0] !== 1'b0) begin
            n_fail++; $display("FAIL glitch_level got %b want 0", btn_level[0]);
         end
      end
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++; $display("FAIL glitch event_count got %0d want 0", obs_q.size());
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_press_release();
      int k;
      k = cyc;
      push_raw = 5'b00010;
      exp_q.push_back(ev(k + 6, 5'h02, 5'h02, 5'h0, 5'h02, 1'b1));
      if (AR) begin
         for (int t = k + 16; t < k + 26; t += 3)
            exp_q.push_back(ev(t, 5'h02, 5'h0, 5'h0, 5'h02, 1'b0));
      end
      exp_q.push_back(ev(k + 26, 5'h0, 5'h0, 5'h02, 5'h0, 1'b0));
      repeat (5) @(negedge clk);
      n_checks++;
      if (btn_level[1] !== 1'b0) begin
         n_fail++; $display("FAIL press_level_early got %b want 0", btn_level[1]);
      end
      @(negedge clk);
      n_checks++;
      if (btn_level[1] !== 1'b1) begin
         n_fail++; $display("FAIL press_level_rise got %b want 1", btn_level[1]);
      end
      repeat (14) @(negedge clk);
      push_raw = 5'h0;
      repeat (12) @(negedge clk);
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL press_release event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL press_release event got cyc %0d %h want cyc %0d %h", o.cyc, o, e.cyc, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_auto_repeat();
      int p;
      p = cyc + 6;
      push_raw = 5'b00001;
      exp_q.push_back(ev(p, 5'h01, 5'h01, 5'h0, 5'h01, 1'b1));
      if (AR) begin
         for (int t = p + 10; t < p + 40; t += 3)
            exp_q.push_back(ev(t, 5'h01, 5'h0, 5'h0, 5'h01, 1'b0));
      end
      // Fall lands on an RPT terminal count (p+40): no strobe expected there.
      exp_q.push_back(ev(p + 40, 5'h0, 5'h0, 5'h01, 5'h0, 1'b0));
      repeat (40) @(negedge clk);
      push_raw = 5'h0;
      repeat (12) @(negedge clk);
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL auto_repeat event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL auto_repeat event got cyc %0d %h want cyc %0d %h", o.cyc, o, e.cyc, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_release_at_terminal();
      int p, p2;
      p = cyc + 6;
      push_raw = 5'b00001;
      exp_q.push_back(ev(p, 5'h01, 5'h01, 5'h0, 5'h01, 1'b1));
      exp_q.push_back(ev(p + 10, 5'h0, 5'h0, 5'h01, 5'h0, 1'b0));
      repeat (10) @(negedge clk);
      push_raw = 5'h0;
      repeat (10) @(negedge clk);
      p2 = cyc + 6;
      push_raw = 5'b00001;
      exp_q.push_back(ev(p2, 5'h01, 5'h01, 5'h0, 5'h01, 1'b1));
      if (AR) exp_q.push_back(ev(p2 + 10, 5'h01, 5'h0, 5'h0, 5'h01, 1'b0));
      exp_q.push_back(ev(p2 + 12, 5'h0, 5'h0, 5'h01, 5'h0, 1'b0));
      repeat (12) @(negedge clk);
      push_raw = 5'h0;
      repeat (12) @(negedge clk);
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL terminal event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL terminal event got cyc %0d %h want cyc %0d %h", o.cyc, o, e.cyc, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_back_to_back();
      int k;
      k = cyc;
      push_raw = 5'b10100;
      exp_q.push_back(ev(k + 6, 5'h14, 5'h14, 5'h0, 5'h14, 1'b1));
      exp_q.push_back(ev(k + 14, 5'h0, 5'h0, 5'h14, 5'h0, 1'b0));
      repeat (8) @(negedge clk);
      push_raw = 5'h0;
      repeat (12) @(negedge clk);
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL simultaneous event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t o, e;
         o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL simultaneous event got cyc %0d %h want cyc %0d %h", o.cyc, o, e.cyc, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_reset_mid_press();
      test_glitch();
      test_press_release();
      test_auto_repeat();
      test_release_at_terminal();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
